// File: rtl/dcmac_rx_am_pkg.sv
// dcmac_rx_am_pkg: shared constants, FSM state type and BIP3 helper for the
// receive alignment-marker lock.
package dcmac_rx_am_pkg;

    localparam int DEF_NUM_VL    = 20;
    localparam int DEF_AM_PERIOD = 16384;

    // Ones mark compared bits; BIP3 [39:32] and BIP7 [7:0] are don't-care.
    localparam logic [63:0] AM_CMP_MASK  = 64'hFFFFFF00FFFFFF00;
    localparam logic [1:0]  AM_SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ST_FIND    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } am_state_e;

    // Per-block BIP3 contribution: bit i folds every data bit i+8m; the sync
    // header bits land on BIP bits 3 and 4.
    function automatic logic [7:0] bip3_of(input logic [1:0] sync, input logic [63:0] data);
        logic [7:0] r;
        r = '0;
        for (int m = 0; m < 8; m++) begin
            r = r ^ data[8*m +: 8];
        end
        r[3] = r[3] ^ sync[0];
        r[4] = r[4] ^ sync[1];
        return r;
    endfunction

endpackage

// File: rtl/dcmac_rx_am_match.sv
// dcmac_rx_am_match: stage 1 of the marker lock. Masked compare of the block
// against every configured marker, lowest index wins, result registered.
// With DCMAC_RX_AM_BIP_CHECK_EN defined it also registers the block's BIP3
// contribution and its received BIP3 field.
module dcmac_rx_am_match
    import dcmac_rx_am_pkg::*;
#(
    parameter int NUM_VL = DEF_NUM_VL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [64*NUM_VL-1:0]  marker_id,
    input  logic                  blk_valid,
    input  logic [1:0]            blk_sync,
    input  logic [63:0]           blk_data,
    output logic                  s1_valid,
    output logic                  s1_hit,
    output logic [4:0]            s1_id
`ifdef DCMAC_RX_AM_BIP_CHECK_EN
    ,
    output logic [7:0]            s1_blk_bip,
    output logic [7:0]            s1_am_bip
`endif
);

    logic       hit;
    logic [4:0] hit_id;

    // Parallel masked compare; scanning downwards leaves the lowest match.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int n = NUM_VL - 1; n >= 0; n--) begin
            if ((blk_sync == AM_SYNC_CTRL) &&
                (((blk_data ^ marker_id[64*n +: 64]) & AM_CMP_MASK) == 64'd0)) begin
                hit    = 1'b1;
                hit_id = 5'(n);
            end
        end
    end

    // Stage-1 register: the valid flag follows every cycle, fields hold on gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_id    <= '0;
        end else begin
            s1_valid <= blk_valid;
            if (blk_valid) begin
                s1_hit <= hit;
                s1_id  <= hit_id;
            end
        end
    end

`ifdef DCMAC_RX_AM_BIP_CHECK_EN
    // Stage-1 BIP fields, captured alongside the match result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_blk_bip <= '0;
            s1_am_bip  <= '0;
        end else if (blk_valid) begin
            s1_blk_bip <= bip3_of(blk_sync, blk_data);
            s1_am_bip  <= blk_data[39:32];
        end
    end
`endif

endmodule

// File: rtl/dcmac_rx_am_lock.sv
// dcmac_rx_am_lock: alignment-marker lock for one PCS virtual lane.
// Stage 1 (dcmac_rx_am_match) finds markers, stage 2 runs the
// FIND/CONFIRM/LOCKED machine, period counter and miss counter.
// Optional BIP3 checking is built when DCMAC_RX_AM_BIP_CHECK_EN is defined.
// Stream semantics: rx_blk_valid qualifies one block per cycle with no
// backpressure; invalid cycles advance nothing. All outputs are registered,
// appear two cycles after the block, and the stat pulses last one cycle.
module dcmac_rx_am_lock
    import dcmac_rx_am_pkg::*;
#(
    parameter int NUM_VL        = DEF_NUM_VL,
    parameter int AM_PERIOD     = DEF_AM_PERIOD,
    parameter int AM_MISS_LIMIT = 4
) (
    input  logic                  rx_core_clk,
    input  logic                  rx_core_reset,
    input  logic [64*NUM_VL-1:0]  ctl_rx_vl_marker_id,
    input  logic                  rx_blk_valid,
    input  logic [1:0]            rx_blk_sync,
    input  logic [63:0]           rx_blk_data,
    output logic                  stat_rx_am_lock,
    output logic [4:0]            stat_rx_vl_id,
    output logic                  stat_rx_am_valid,
    output logic                  stat_rx_am_err,
    output logic                  stat_rx_bip_err
);

    localparam int CW = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
    localparam int MW = $clog2(AM_MISS_LIMIT + 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(AM_PERIOD - 1);
    localparam logic [MW-1:0] MISS_LAST   = MW'(AM_MISS_LIMIT - 1);

    logic            s1_valid;
    logic            s1_hit;
    logic [4:0]      s1_id;

    am_state_e       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [MW-1:0]   miss, miss_nxt;
    logic [4:0]      cap_id, cap_id_nxt;
    logic            lock_nxt;
    logic [4:0]      vl_id_nxt;
    logic            am_valid_nxt;
    logic            am_err_nxt;
    logic            slot;
    logic            id_ok;

`ifdef DCMAC_RX_AM_BIP_CHECK_EN
    logic [7:0]      s1_blk_bip;
    logic [7:0]      s1_am_bip;
`endif

    dcmac_rx_am_match #(
        .NUM_VL (NUM_VL)
    ) u_match (
        .clk        (rx_core_clk),
        .rst        (rx_core_reset),
        .marker_id  (ctl_rx_vl_marker_id),
        .blk_valid  (rx_blk_valid),
        .blk_sync   (rx_blk_sync),
        .blk_data   (rx_blk_data),
        .s1_valid   (s1_valid),
        .s1_hit     (s1_hit),
        .s1_id      (s1_id)
`ifdef DCMAC_RX_AM_BIP_CHECK_EN
        ,
        .s1_blk_bip (s1_blk_bip),
        .s1_am_bip  (s1_am_bip)
`endif
    );

    assign slot  = (cnt == '0);
    assign id_ok = s1_hit && (s1_id == cap_id);

    // Next-state and output decode; only valid stage-1 blocks move anything.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        miss_nxt     = miss;
        cap_id_nxt   = cap_id;
        lock_nxt     = stat_rx_am_lock;
        vl_id_nxt    = stat_rx_vl_id;
        am_valid_nxt = 1'b0;
        am_err_nxt   = 1'b0;
        if (s1_valid) begin
            case (state)
                ST_FIND: begin
                    if (s1_hit) begin
                        cap_id_nxt = s1_id;
                        cnt_nxt    = PERIOD_LOAD;
                        state_nxt  = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (slot) begin
                        miss_nxt = '0;
                        if (id_ok) begin
                            state_nxt = ST_LOCKED;
                            lock_nxt  = 1'b1;
                            vl_id_nxt = cap_id;
                            cnt_nxt   = PERIOD_LOAD;
                        end else begin
                            // The slot block is consumed here, not re-searched.
                            state_nxt = ST_FIND;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (slot) begin
                        cnt_nxt = PERIOD_LOAD;
                        if (id_ok) begin
                            am_valid_nxt = 1'b1;
                            miss_nxt     = '0;
                        end else begin
                            am_err_nxt = 1'b1;
                            if (miss == MISS_LAST) begin
                                state_nxt = ST_FIND;
                                lock_nxt  = 1'b0;
                                miss_nxt  = '0;
                                cnt_nxt   = '0;
                            end else begin
                                miss_nxt = miss + 1'b1;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_FIND;
                    cnt_nxt   = '0;
                    miss_nxt  = '0;
                end
            endcase
        end
    end

    // Stage-2 register: FSM, counters and status outputs.
    always_ff @(posedge rx_core_clk or posedge rx_core_reset) begin
        if (rx_core_reset) begin
            state            <= ST_FIND;
            cnt              <= '0;
            miss             <= '0;
            cap_id           <= '0;
            stat_rx_am_lock  <= 1'b0;
            stat_rx_vl_id    <= '0;
            stat_rx_am_valid <= 1'b0;
            stat_rx_am_err   <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            miss             <= miss_nxt;
            cap_id           <= cap_id_nxt;
            stat_rx_am_lock  <= lock_nxt;
            stat_rx_vl_id    <= vl_id_nxt;
            stat_rx_am_valid <= am_valid_nxt;
            stat_rx_am_err   <= am_err_nxt;
        end
    end

`ifdef DCMAC_RX_AM_BIP_CHECK_EN
    logic [7:0] bip_acc;
    logic       bip_armed;

    // BIP3 accumulate/compare; a full period must be seen before a compare,
    // so the lock marker and any slot after a miss only reseed.
    always_ff @(posedge rx_core_clk or posedge rx_core_reset) begin
        if (rx_core_reset) begin
            bip_acc         <= '0;
            bip_armed       <= 1'b0;
            stat_rx_bip_err <= 1'b0;
        end else begin
            stat_rx_bip_err <= 1'b0;
            if (s1_valid) begin
                if ((state == ST_CONFIRM) && slot && id_ok) begin
                    bip_acc   <= s1_blk_bip;
                    bip_armed <= 1'b0;
                end else if (state == ST_LOCKED) begin
                    if (slot) begin
                        stat_rx_bip_err <= id_ok && bip_armed && (bip_acc != s1_am_bip);
                        bip_acc         <= s1_blk_bip;
                        bip_armed       <= id_ok;
                    end else begin
                        bip_acc <= bip_acc ^ s1_blk_bip;
                    end
                end
            end
        end
    end
`else
    assign stat_rx_bip_err = 1'b0;
`endif

endmodule

// File: tb/tb_dcmac_rx_am_lock.sv
// tb_dcmac_rx_am_lock: directed marker streams with a scoreboard of expected
// status events (lock edges and stat pulses) and their arrival cycle.
module tb_dcmac_rx_am_lock;

    localparam int NUM_VL        = 20;
    localparam int AM_PERIOD     = 32;
    localparam int AM_MISS_LIMIT = 4;
`ifdef DCMAC_RX_AM_BIP_CHECK_EN
    localparam logic BIP_ON = 1'b1;
`else
    localparam logic BIP_ON = 1'b0;
`endif

    logic                  rx_core_clk;
    logic                  rx_core_reset;
    logic [64*NUM_VL-1:0]  ctl_rx_vl_marker_id;
    logic                  rx_blk_valid;
    logic [1:0]            rx_blk_sync;
    logic [63:0]           rx_blk_data;
    logic                  stat_rx_am_lock;
    logic [4:0]            stat_rx_vl_id;
    logic                  stat_rx_am_valid;
    logic                  stat_rx_am_err;
    logic                  stat_rx_bip_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gap_pct = 0;
    int          t_drive;
    logic [7:0]  bip_run = '0;
    logic [8:0]  exp_q[$];
    int          exp_t[$];
    logic        prev_lock = 1'b0;
    logic [8:0]  mon_got;
    logic [8:0]  mon_want;
    int          mon_t;
    logic [64*NUM_VL-1:0] tbl;
    logic [64*NUM_VL-1:0] tbl_dup;
    logic [63:0] tmp;

    dcmac_rx_am_lock #(
        .NUM_VL        (NUM_VL),
        .AM_PERIOD     (AM_PERIOD),
        .AM_MISS_LIMIT (AM_MISS_LIMIT)
    ) dut (
        .rx_core_clk         (rx_core_clk),
        .rx_core_reset       (rx_core_reset),
        .ctl_rx_vl_marker_id (ctl_rx_vl_marker_id),
        .rx_blk_valid        (rx_blk_valid),
        .rx_blk_sync         (rx_blk_sync),
        .rx_blk_data         (rx_blk_data),
        .stat_rx_am_lock     (stat_rx_am_lock),
        .stat_rx_vl_id       (stat_rx_vl_id),
        .stat_rx_am_valid    (stat_rx_am_valid),
        .stat_rx_am_err      (stat_rx_am_err),
        .stat_rx_bip_err     (stat_rx_bip_err)
    );

    // Clock and cycle counter.
    initial rx_core_clk = 1'b0;
    always #5 rx_core_clk = ~rx_core_clk;
    always @(posedge rx_core_clk) cyc <= cyc + 1;

    function automatic logic [63:0] mk(input int n);
        logic [7:0] a, b, c;
        a = 8'h11 + 8'(n * 7);
        b = 8'h4A ^ 8'(n);
        c = 8'h90 + 8'(n * 3);
        return {a, b, c, 8'h00, ~a, ~b, ~c, 8'h00};
    endfunction

    function automatic logic [7:0] bip_of(input logic [1:0] s, input logic [63:0] d);
        logic [7:0] r;
        r = '0;
        for (int m = 0; m < 8; m++) r = r ^ d[8*m +: 8];
        r[3] = r[3] ^ s[0];
        r[4] = r[4] ^ s[1];
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [8:0] ev(input logic l, input logic [4:0] id, input logic v,
                                      input logic e, input logic b);
        return {l, id, v, e, b};
    endfunction

    // Marker block for a lane, carrying the transmitter's BIP3 and random BIP7.
    function automatic logic [63:0] am_blk(input int id);
        logic [63:0] d;
        d = mk(id);
        d[39:32] = bip_run;
        d[7:0]   = 8'($urandom_range(255));
        return d;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [63:0] d);
        rx_blk_valid = v;
        rx_blk_sync  = s;
        rx_blk_data  = d;
        @(posedge rx_core_clk);
        #1;
    endtask

    // One valid block, optionally preceded by idle cycles that carry a
    // marker pattern; acc_d is what the transmitter folded into its BIP3.
    task automatic send_slot(input logic [1:0] s, input logic [63:0] d, input logic [63:0] acc_d,
                             input logic seed, input logic has_ev, input logic [8:0] e);
        int g = 0;
        while (g < 3 && $urandom_range(99) < gap_pct) begin
            drive(1'b0, 2'b10, mk(0));
            g++;
        end
        t_drive = cyc;
        drive(1'b1, s, d);
        if (seed) bip_run = bip_of(s, acc_d);
        else      bip_run = bip_run ^ bip_of(s, acc_d);
        if (has_ev) begin
            exp_q.push_back(e);
            exp_t.push_back(t_drive + 2);
        end
    endtask

    task automatic send_data(input int n, input int flip_at);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd64();
            send_slot(2'b01, (i == flip_at) ? (d ^ 64'h200) : d, d, 1'b0, 1'b0, 9'd0);
        end
    endtask

    task automatic send_am(input int id, input logic has_ev, input logic [8:0] e);
        logic [63:0] d;
        d = am_blk(id);
        send_slot(2'b10, d, d, 1'b1, has_ev, e);
    endtask

    task automatic period(input int id, input logic has_ev, input logic [8:0] e);
        send_am(id, has_ev, e);
        send_data(AM_PERIOD - 1, -1);
    endtask

    task automatic bad_period(input logic [1:0] s, input logic [63:0] d, input logic [8:0] e);
        send_slot(s, d, d, 1'b0, 1'b1, e);
        send_data(AM_PERIOD - 1, -1);
    endtask

    // One-cycle asynchronous reset; the marker table may change while held.
    task automatic pulse_reset(input logic [64*NUM_VL-1:0] new_tbl);
        chk("queue_drained_before_reset", 8'(exp_q.size()), 8'd0);
        rx_blk_valid = 1'b0;
        @(posedge rx_core_clk);
        #2;
        rx_core_reset = 1'b1;
        #1;
        chk("reset_lock", {7'd0, stat_rx_am_lock}, 8'd0);
        chk("reset_vl_id", {3'd0, stat_rx_vl_id}, 8'd0);
        chk("reset_am_valid", {7'd0, stat_rx_am_valid}, 8'd0);
        chk("reset_am_err", {7'd0, stat_rx_am_err}, 8'd0);
        chk("reset_bip_err", {7'd0, stat_rx_bip_err}, 8'd0);
        ctl_rx_vl_marker_id = new_tbl;
        @(posedge rx_core_clk);
        #2;
        rx_core_reset = 1'b0;
        bip_run = '0;
        @(posedge rx_core_clk);
        #1;
    endtask

    // Monitor: every lock edge or stat pulse must match the queue head,
    // on the cycle it was expected.
    always @(negedge rx_core_clk) begin
        if (rx_core_reset) begin
            prev_lock = 1'b0;
        end else begin
            if (stat_rx_am_valid || stat_rx_am_err || stat_rx_bip_err ||
                (stat_rx_am_lock != prev_lock)) begin
                mon_got = {stat_rx_am_lock, stat_rx_vl_id, stat_rx_am_valid,
                           stat_rx_am_err, stat_rx_bip_err};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %h at cycle %0d, required no event",
                             mon_got, cyc);
                end else begin
                    mon_want = exp_q.pop_front();
                    mon_t    = exp_t.pop_front();
                    if (mon_got !== mon_want || cyc != mon_t) begin
                        errors++;
                        $display("FAIL event {lock,id,valid,err,bip}: got %h at cycle %0d, required %h at cycle %0d",
                                 mon_got, cyc, mon_want, mon_t);
                    end
                end
            end
            prev_lock = stat_rx_am_lock;
        end
    end

    // Directed scenarios.
    initial begin
        rx_core_reset = 1'b0;
        rx_blk_valid  = 1'b0;
        rx_blk_sync   = 2'b00;
        rx_blk_data   = '0;
        for (int n = 0; n < NUM_VL; n++) tbl[64*n +: 64] = mk(n);
        ctl_rx_vl_marker_id = tbl;
        #2;
        rx_core_reset = 1'b1;
        #1;
        chk("init_lock", {7'd0, stat_rx_am_lock}, 8'd0);
        chk("init_vl_id", {3'd0, stat_rx_vl_id}, 8'd0);
        chk("init_am_valid", {7'd0, stat_rx_am_valid}, 8'd0);
        chk("init_am_err", {7'd0, stat_rx_am_err}, 8'd0);
        chk("init_bip_err", {7'd0, stat_rx_bip_err}, 8'd0);
        repeat (2) @(posedge rx_core_clk);
        #2;
        rx_core_reset = 1'b0;
        @(posedge rx_core_clk);
        #1;

        // Lock on ID 5, steady markers, one BIP-corrupted period, a stray
        // marker between slots.
        period(5, 1'b0, 9'd0);
        period(5, 1'b1, ev(1'b1, 5'd5, 1'b0, 1'b0, 1'b0));
        period(5, 1'b1, ev(1'b1, 5'd5, 1'b1, 1'b0, 1'b0));
        send_am(5, 1'b1, ev(1'b1, 5'd5, 1'b1, 1'b0, 1'b0));
        send_data(AM_PERIOD - 1, 10);
        send_am(5, 1'b1, ev(1'b1, 5'd5, 1'b1, 1'b0, BIP_ON));
        send_data(8, -1);
        tmp = am_blk(5);
        send_slot(2'b10, tmp, tmp, 1'b0, 1'b0, 9'd0);
        send_data(AM_PERIOD - 10, -1);
        period(5, 1'b1, ev(1'b1, 5'd5, 1'b1, 1'b0, 1'b0));

        // ID 3 then ID 7: no lock; 7 twice more locks on 7.
        pulse_reset(tbl);
        period(3, 1'b0, 9'd0);
        period(7, 1'b0, 9'd0);
        send_am(7, 1'b0, 9'd0);
        send_data(5, -1);
        tmp = am_blk(2);
        send_slot(2'b10, tmp, tmp, 1'b0, 1'b0, 9'd0);
        send_data(AM_PERIOD - 7, -1);
        period(7, 1'b1, ev(1'b1, 5'd7, 1'b0, 1'b0, 1'b0));
        bad_period(2'b10, am_blk(9), ev(1'b1, 5'd7, 1'b0, 1'b1, 1'b0));

        // Mid-lock reset, relock on ID 0, then the miss-count sequences.
        pulse_reset(tbl);
        period(0, 1'b0, 9'd0);
        period(0, 1'b1, ev(1'b1, 5'd0, 1'b0, 1'b0, 1'b0));
        bad_period(2'b01, am_blk(0), ev(1'b1, 5'd0, 1'b0, 1'b1, 1'b0));
        tmp = am_blk(0);
        tmp[40] = ~tmp[40];
        bad_period(2'b10, tmp, ev(1'b1, 5'd0, 1'b0, 1'b1, 1'b0));
        bad_period(2'b10, am_blk(9), ev(1'b1, 5'd0, 1'b0, 1'b1, 1'b0));
        period(0, 1'b1, ev(1'b1, 5'd0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            bad_period(2'b01, rnd64(), ev(1'b1, 5'd0, 1'b0, 1'b1, 1'b0));
        end
        bad_period(2'b01, rnd64(), ev(1'b0, 5'd0, 1'b0, 1'b1, 1'b0));
        period(0, 1'b0, 9'd0);
        period(0, 1'b1, ev(1'b1, 5'd0, 1'b0, 1'b0, 1'b0));

        // Locked stream with idle cycles mixed in.
        gap_pct = 30;
        for (int i = 0; i < 3; i++) period(0, 1'b1, ev(1'b1, 5'd0, 1'b1, 1'b0, 1'b0));
        gap_pct = 0;

        // ID 12 duplicates ID 4's pattern: the lower index is reported.
        tbl_dup = tbl;
        tbl_dup[64*12 +: 64] = tbl[64*4 +: 64];
        pulse_reset(tbl_dup);
        period(4, 1'b0, 9'd0);
        period(4, 1'b1, ev(1'b1, 5'd4, 1'b0, 1'b0, 1'b0));
        period(4, 1'b1, ev(1'b1, 5'd4, 1'b1, 1'b0, 1'b0));

        // Highest lane index.
        pulse_reset(tbl);
        period(19, 1'b0, 9'd0);
        period(19, 1'b1, ev(1'b1, 5'd19, 1'b0, 1'b0, 1'b0));
        period(19, 1'b1, ev(1'b1, 5'd19, 1'b1, 1'b0, 1'b0));

        repeat (8) drive(1'b0, 2'b01, 64'd0);
        chk("queue_drained_at_end", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
